// File: rtl/flag_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : flag_unit_pkg
//  Description : Shared condition-code and flag-index constants for flag_unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package flag_unit_pkg;

    localparam int FLAG_Z = 0;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 2;

    localparam logic [2:0] CC_NE  = 3'b000;
    localparam logic [2:0] CC_EQ  = 3'b001;
    localparam logic [2:0] CC_GT  = 3'b010;
    localparam logic [2:0] CC_LT  = 3'b011;
    localparam logic [2:0] CC_GE  = 3'b100;
    localparam logic [2:0] CC_LE  = 3'b101;
    localparam logic [2:0] CC_OV  = 3'b110;
    localparam logic [2:0] CC_UNC = 3'b111;

endpackage
`default_nettype wire

// File: rtl/flag_unit_cond_eval.sv
`default_nettype none
// ============================================================================
//  Module      : cond_eval
//  Description : Combinational branch-condition decode over Z/V/N flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module cond_eval
    import flag_unit_pkg::*;
(
    input  logic [2:0] flags,
    input  logic [2:0] cond,
    output logic       taken
);

    logic w_z;
    logic w_v;
    logic w_n;

    assign w_z = flags[FLAG_Z];
    assign w_v = flags[FLAG_V];
    assign w_n = flags[FLAG_N];

    always_comb begin
        taken = 1'b0;
        unique case (cond)
            CC_NE:   taken = ~w_z;
            CC_EQ:   taken = w_z;
            CC_GT:   taken = ~w_z & ~w_n;
            CC_LT:   taken = w_n;
            CC_GE:   taken = w_z | ~w_n;
            CC_LE:   taken = w_z | w_n;
            CC_OV:   taken = w_v;
            CC_UNC:  taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/flag_unit.sv
`default_nettype none
// ============================================================================
//  Module      : flag_unit
//  Description : Pipeline flag register with zero-cycle forwarding, pending
//                flag-setter tracking and branch evaluation. Defining
//                FLAG_SHADOW_EN adds a save/restore shadow flag register.
//  Revision    : 1.0 - initial release
// ============================================================================
module flag_unit
    import flag_unit_pkg::*;
#(
    parameter int NFLAGS   = 3,
    parameter int PEND_MAX = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NFLAGS-1:0] d,
    input  logic [NFLAGS-1:0] wen,
    input  logic              set_issue,
    input  logic              flush,
    input  logic              cond_valid,
    input  logic [2:0]        cond,
    output logic [NFLAGS-1:0] q,
    output logic              cond_ready,
    output logic              taken,
    output logic              pend_full
`ifdef FLAG_SHADOW_EN
    ,
    input  logic              save,
    input  logic              restore
`endif
);

    localparam int               c_PCW      = $clog2(PEND_MAX + 1);
    localparam logic [c_PCW-1:0] c_PEND_MAX = c_PCW'(PEND_MAX);

    logic [NFLAGS-1:0] r_q;
    logic [NFLAGS-1:0] w_q_nxt;
    logic [NFLAGS-1:0] w_wmask;
    logic [NFLAGS-1:0] w_f;
    logic [c_PCW-1:0]  r_pc;
    logic [c_PCW-1:0]  w_pc_nxt;
    logic              w_any_wen;
    logic              w_taken_raw;

    // A flushed cycle writes nothing, so the bypass sees the old flags too.
    assign w_wmask   = flush ? '0 : wen;
    assign w_f       = (d & w_wmask) | (r_q & ~w_wmask);
    assign w_any_wen = |wen;

    cond_eval u_cond_eval (
        .flags ({w_f[FLAG_N], w_f[FLAG_V], w_f[FLAG_Z]}),
        .cond  (cond),
        .taken (w_taken_raw)
    );

    assign taken      = cond_valid & w_taken_raw;
    assign pend_full  = (r_pc == c_PEND_MAX);
    // The last outstanding setter writing this cycle is covered by the bypass.
    assign cond_ready = (cond == CC_UNC) || (r_pc == '0) ||
                        ((r_pc == c_PCW'(1)) && w_any_wen && !flush);
    assign q          = r_q;

    always_comb begin
        w_pc_nxt = r_pc;
        if (flush) begin
            w_pc_nxt = '0;
        end else if (set_issue && !w_any_wen) begin
            if (r_pc != c_PEND_MAX) w_pc_nxt = r_pc + 1'b1;
        end else if (!set_issue && w_any_wen) begin
            if (r_pc != '0) w_pc_nxt = r_pc - 1'b1;
        end
    end

`ifdef FLAG_SHADOW_EN
    logic [NFLAGS-1:0] r_shadow;

    assign w_q_nxt = restore ? r_shadow : w_f;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shadow <= '0;
        end else if (save) begin
            r_shadow <= r_q;
        end
    end
`else
    assign w_q_nxt = w_f;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q  <= '0;
            r_pc <= '0;
        end else begin
            r_q  <= w_q_nxt;
            r_pc <= w_pc_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_flag_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_flag_unit
//  Description : Self-checking bench for flag_unit with a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_flag_unit;

    localparam int NF   = 3;
    localparam int PMAX = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [NF-1:0] d = '0;
    logic [NF-1:0] wen = '0;
    logic          set_issue = 1'b0;
    logic          flush = 1'b0;
    logic          cond_valid = 1'b0;
    logic [2:0]    cond = 3'b000;
    logic [NF-1:0] q;
    logic          cond_ready;
    logic          taken;
    logic          pend_full;
`ifdef FLAG_SHADOW_EN
    logic          save = 1'b0;
    logic          restore = 1'b0;
`endif

    int tests = 0;
    int fails = 0;

    // Behavioural model state
    logic [NF-1:0] mq = '0;
    logic [NF-1:0] msh = '0;
    int            mpc = 0;

    flag_unit #(.NFLAGS(NF), .PEND_MAX(PMAX)) dut (
        .clk        (clk),
        .rst        (rst),
        .d          (d),
        .wen        (wen),
        .set_issue  (set_issue),
        .flush      (flush),
        .cond_valid (cond_valid),
        .cond       (cond),
        .q          (q),
        .cond_ready (cond_ready),
        .taken      (taken),
        .pend_full  (pend_full)
`ifdef FLAG_SHADOW_EN
        ,
        .save       (save),
        .restore    (restore)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [NF-1:0] m_f();
        logic [NF-1:0] r;
        for (int i = 0; i < NF; i++)
            r[i] = (wen[i] && !flush) ? d[i] : mq[i];
        return r;
    endfunction

    function automatic logic m_taken();
        logic [NF-1:0] f;
        logic z, v, n, t;
        f = m_f();
        z = f[0]; v = f[1]; n = f[2];
        case (cond)
            3'd0: t = (z == 1'b0);
            3'd1: t = (z == 1'b1);
            3'd2: t = (z == 1'b0) && (n == 1'b0);
            3'd3: t = (n == 1'b1);
            3'd4: t = (z == 1'b1) || (n == 1'b0);
            3'd5: t = (z == 1'b1) || (n == 1'b1);
            3'd6: t = (v == 1'b1);
            default: t = 1'b1;
        endcase
        return cond_valid && t;
    endfunction

    function automatic logic m_ready();
        return (cond == 3'd7) || (mpc == 0) || (mpc == 1 && wen != 0 && !flush);
    endfunction

    task automatic drive(input logic [NF-1:0] dd, input logic [NF-1:0] ww,
                         input logic si, input logic fl,
                         input logic cv, input logic [2:0] cc);
        d = dd; wen = ww; set_issue = si; flush = fl; cond_valid = cv; cond = cc;
`ifdef FLAG_SHADOW_EN
        save = 1'b0; restore = 1'b0;
`endif
    endtask

    // Advance the model by the rules for one rising edge, then the clock.
    task automatic step();
        logic [NF-1:0] nq;
        nq = m_f();
`ifdef FLAG_SHADOW_EN
        if (restore) nq = msh;
        if (save) msh = mq;
`endif
        if (flush) mpc = 0;
        else if (set_issue && wen == 0) mpc = (mpc < PMAX) ? mpc + 1 : PMAX;
        else if (!set_issue && wen != 0) mpc = (mpc > 0) ? mpc - 1 : 0;
        mq = nq;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive('0, '0, 1'b0, 1'b0, 1'b0, 3'b000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        tests++; if (q !== 3'b000) begin fails++; $display("FAIL reset_q got=%b exp=000", q); end
        tests++; if (pend_full !== 1'b0) begin fails++; $display("FAIL reset_pend_full got=%b exp=0", pend_full); end
        tests++; if (cond_ready !== 1'b1) begin fails++; $display("FAIL reset_cond_ready got=%b exp=1", cond_ready); end
        tests++; if (taken !== 1'b0) begin fails++; $display("FAIL reset_taken got=%b exp=0", taken); end
        rst = 1'b1;
        mq = '0; msh = '0; mpc = 0;
    endtask

    task automatic test_write_and_eval();
        @(negedge clk);
        drive(3'b001, 3'b111, 1'b0, 1'b0, 1'b0, 3'b000);
        step();
        tests++; if (q !== 3'b001) begin fails++; $display("FAIL write_q got=%b exp=001", q); end
        @(negedge clk);
        drive('0, '0, 1'b0, 1'b0, 1'b1, 3'b001);
        #1;
        tests++; if (taken !== 1'b1) begin fails++; $display("FAIL eq_taken got=%b exp=1", taken); end
        cond_valid = 1'b0;
        #1;
        tests++; if (taken !== 1'b0) begin fails++; $display("FAIL invalid_taken got=%b exp=0", taken); end
        step();
    endtask

    task automatic test_forwarding();
        @(negedge clk);
        drive(3'b000, 3'b111, 1'b0, 1'b0, 1'b0, 3'b000);
        step();
        @(negedge clk);
        drive(3'b100, 3'b100, 1'b0, 1'b0, 1'b1, 3'b011);
        #1;
        tests++; if (taken !== 1'b1) begin fails++; $display("FAIL fwd_lt_taken got=%b exp=1", taken); end
        step();
        tests++; if (q[2] !== 1'b1) begin fails++; $display("FAIL fwd_q2 got=%b exp=1", q[2]); end
    endtask

    task automatic test_pending();
        repeat (2) begin
            @(negedge clk);
            drive('0, '0, 1'b1, 1'b0, 1'b0, 3'b000);
            step();
        end
        @(negedge clk);
        drive('0, '0, 1'b0, 1'b0, 1'b1, 3'b000);
        #1;
        tests++; if (cond_ready !== 1'b0) begin fails++; $display("FAIL pend2_ready got=%b exp=0", cond_ready); end
        drive(3'b001, 3'b001, 1'b0, 1'b0, 1'b1, 3'b000);
        #1;
        tests++; if (cond_ready !== 1'b0) begin fails++; $display("FAIL first_write_ready got=%b exp=0", cond_ready); end
        step();
        @(negedge clk);
        drive(3'b000, 3'b001, 1'b0, 1'b0, 1'b1, 3'b000);
        #1;
        tests++; if (cond_ready !== 1'b1) begin fails++; $display("FAIL second_write_ready got=%b exp=1", cond_ready); end
        tests++; if (taken !== 1'b1) begin fails++; $display("FAIL second_write_ne got=%b exp=1", taken); end
        step();
    endtask

    task automatic test_saturate_flush();
        logic [NF-1:0] qb;
        repeat (4) begin
            @(negedge clk);
            drive('0, '0, 1'b1, 1'b0, 1'b0, 3'b000);
            step();
        end
        tests++; if (pend_full !== 1'b1) begin fails++; $display("FAIL sat_pend_full got=%b exp=1", pend_full); end
        @(negedge clk);
        drive('0, '0, 1'b0, 1'b0, 1'b1, 3'b111);
        #1;
        tests++; if (cond_ready !== 1'b1) begin fails++; $display("FAIL unc_ready got=%b exp=1", cond_ready); end
        tests++; if (taken !== 1'b1) begin fails++; $display("FAIL unc_taken got=%b exp=1", taken); end
        qb = q;
        drive(~qb, 3'b111, 1'b1, 1'b1, 1'b0, 3'b000);
        step();
        tests++; if (q !== qb) begin fails++; $display("FAIL flush_q got=%b exp=%b", q, qb); end
        tests++; if (pend_full !== 1'b0) begin fails++; $display("FAIL flush_pend_full got=%b exp=0", pend_full); end
        @(negedge clk);
        drive('0, '0, 1'b0, 1'b0, 1'b0, 3'b000);
        #1;
        tests++; if (cond_ready !== 1'b1) begin fails++; $display("FAIL flush_ready got=%b exp=1", cond_ready); end
    endtask

    task automatic test_async_reset();
        repeat (2) begin
            @(negedge clk);
            drive('0, '0, 1'b1, 1'b0, 1'b0, 3'b000);
            step();
        end
        @(negedge clk);
        drive(3'b111, 3'b111, 1'b0, 1'b0, 1'b0, 3'b000);
        #2;
        rst = 1'b0;
        #1;
        tests++; if (q !== 3'b000) begin fails++; $display("FAIL async_q got=%b exp=000", q); end
        tests++; if (pend_full !== 1'b0) begin fails++; $display("FAIL async_pend_full got=%b exp=0", pend_full); end
        tests++; if (cond_ready !== 1'b1) begin fails++; $display("FAIL async_ready got=%b exp=1", cond_ready); end
        mq = '0; msh = '0; mpc = 0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        drive(3'b010, 3'b010, 1'b0, 1'b0, 1'b0, 3'b000);
        step();
        tests++; if (q !== 3'b010) begin fails++; $display("FAIL post_reset_q got=%b exp=010", q); end
        tests++; if (pend_full !== 1'b0) begin fails++; $display("FAIL post_reset_full got=%b exp=0", pend_full); end
    endtask

`ifdef FLAG_SHADOW_EN
    task automatic test_shadow();
        @(negedge clk);
        drive(3'b101, 3'b111, 1'b0, 1'b0, 1'b0, 3'b000);
        step();
        @(negedge clk);
        drive('0, '0, 1'b0, 1'b0, 1'b0, 3'b000);
        save = 1'b1;
        step();
        @(negedge clk);
        drive(3'b010, 3'b111, 1'b0, 1'b0, 1'b0, 3'b000);
        step();
        tests++; if (q !== 3'b010) begin fails++; $display("FAIL shadow_write_q got=%b exp=010", q); end
        @(negedge clk);
        drive(3'b000, 3'b111, 1'b0, 1'b0, 1'b0, 3'b000);
        restore = 1'b1;
        step();
        tests++; if (q !== 3'b101) begin fails++; $display("FAIL shadow_restore_q got=%b exp=101", q); end
        @(negedge clk);
        drive('0, '0, 1'b0, 1'b0, 1'b0, 3'b000);
        save = 1'b1; restore = 1'b1;
        step();
        tests++; if (q !== 3'b101) begin fails++; $display("FAIL shadow_swap_q got=%b exp=101", q); end
        @(negedge clk);
        drive('0, '0, 1'b0, 1'b0, 1'b0, 3'b000);
        restore = 1'b1;
        step();
        tests++; if (q !== 3'b101) begin fails++; $display("FAIL shadow_swap_back got=%b exp=101", q); end
    endtask
`endif

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            drive(NF'($urandom), ($urandom_range(0, 2) == 0) ? '0 : NF'($urandom),
                  $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0,
                  1'($urandom), 3'($urandom));
`ifdef FLAG_SHADOW_EN
            save = ($urandom_range(0, 7) == 0);
            restore = ($urandom_range(0, 7) == 0);
`endif
            #1;
            tests++; if (taken !== m_taken()) begin fails++; $display("FAIL rnd_taken n=%0d got=%b exp=%b", n, taken, m_taken()); end
            tests++; if (cond_ready !== m_ready()) begin fails++; $display("FAIL rnd_ready n=%0d got=%b exp=%b", n, cond_ready, m_ready()); end
            tests++; if (pend_full !== (mpc == PMAX)) begin fails++; $display("FAIL rnd_full n=%0d got=%b exp=%b", n, pend_full, mpc == PMAX); end
            step();
            tests++; if (q !== mq) begin fails++; $display("FAIL rnd_q n=%0d got=%b exp=%b", n, q, mq); end
        end
    endtask

    initial begin
        test_reset();
        test_write_and_eval();
        test_forwarding();
        test_pending();
        test_saturate_flush();
        test_async_reset();
`ifdef FLAG_SHADOW_EN
        test_shadow();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/flag_unit.md
FLAG_UNIT -- requirements
Module: flag_unit

Interface
REQ-001 Parameter NFLAGS, default 3, flag count (bit0 Z, bit1 V, bit2 N, higher bits generic); SHALL be >= 3.
REQ-002 Parameter PEND_MAX, default 3, maximum in-flight flag-setting instructions tracked.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 d  input  NFLAGS  new flag values from execute stage.
REQ-006 wen  input  NFLAGS  per-flag write mask.
REQ-007 set_issue  input  1  pulse: a flag-setting instruction entered the pipeline.
REQ-008 flush  input  1  pipeline flush: suppresses this cycle's write and clears pending count.
REQ-009 cond_valid  input  1  branch requests evaluation this cycle.
REQ-010 cond  input  3  condition code.
REQ-011 q  output  NFLAGS  registered flags.
REQ-012 cond_ready  output  1  evaluation result is trustworthy this cycle.
REQ-013 taken  output  1  branch decision, meaningful only when cond_valid and cond_ready.
REQ-014 pend_full  output  1  pending count equals PEND_MAX.

Function
REQ-015 Each q[i] SHALL load d[i] on the edge where wen[i]=1 and flush=0, else hold.
REQ-016 Bypassed flags f SHALL equal d[i] where wen[i]=1 and flush=0, else q[i]; evaluation uses f, zero-cycle forwarding.
REQ-017 taken SHALL decode cond on f: 000 NE Z=0; 001 EQ Z=1; 010 GT Z=0&N=0; 011 LT N=1; 100 GE Z=1|N=0; 101 LE Z=1|N=1; 110 OV V=1; 111 always 1.
REQ-018 Pending counter pc (0..PEND_MAX) SHALL: +1 on set_issue alone; -1 on any wen bit alone (floor 0); unchanged when both; cleared to 0 on flush (flush dominates set_issue).
REQ-019 cond_ready SHALL be 1 when cond=111, or pc=0, or (pc=1 and any wen bit set and flush=0); else 0.
REQ-020 set_issue when pc=PEND_MAX and no write SHALL leave pc saturated; pend_full stays 1.
REQ-021 taken SHALL be 0 when cond_valid=0.
REQ-022 All outputs except q are combinational from state and inputs; q latency one cycle.

Reset
REQ-023 rst low SHALL immediately force q=0, pc=0, shadow=0; thus pend_full=0, cond_ready=1 when idle.
REQ-024 Reset asserted mid-operation SHALL discard any write and pending count; first edge after release behaves as from idle.

Configuration
REQ-025 Macro FLAG_SHADOW_EN SHALL add inputs save, restore (1 bit each) and an NFLAGS shadow register.
REQ-026 With FLAG_SHADOW_EN: save loads shadow<=q; restore loads q<=shadow with priority over wen; save+restore same cycle swaps (q<=shadow, shadow<=old q).
REQ-027 Without FLAG_SHADOW_EN: no save/restore ports, no shadow storage; behaviour per REQ-015..024.

Structure
REQ-028 Shared package SHALL hold condition-code constants (CC_NE..CC_UNC), flag bit index constants (FLAG_Z=0, FLAG_V=1, FLAG_N=2).
REQ-029 Condition decode SHALL be a sub-module cond_eval (flags in, cond in, taken out), purely combinational.

Verification
REQ-030 Reset, then d=3'b001 wen=3'b111 -> next cycle q=3'b001; cond=001 valid -> taken=1.
REQ-031 q=3'b000, wen=3'b100 d=3'b100 same cycle as cond=011 -> taken=1 (forwarded), q[2]=1 next cycle.
REQ-032 Two set_issue pulses, then cond=000 -> cond_ready=0; first write -> still 0; second write cycle -> cond_ready=1.
REQ-033 Four set_issue with PEND_MAX=3 -> pend_full=1, pc=3; flush -> pc=0, write that cycle ignored.
REQ-034 FLAG_SHADOW_EN: q=3'b101, save; write 3'b010; restore together with wen=3'b111 -> q=3'b101.
REQ-035 Assert rst low mid-write with pc=2 -> q=0, pc=0 asynchronously, cond_ready=1.
